// File: rtl/mult_seq_controller.sv
// mult_seq_controller: control FSM for a sequential shift-and-add multiplier.
// Latency: load_signal 1 cycle after start is sampled, done WIDTH+popcount(Q)+2 cycles after.
// Backpressure: none; start is honoured only in IDLE, otherwise dropped (never queued).
// Optional: define MULT_CYCLE_COUNT_EN to add the cycle_count [7:0] output.
module mult_seq_controller #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic lsb,
  output logic load_signal,
  output logic add_signal,
  output logic shift_signal,
  output logic out_signal,
  output logic busy,
  output logic done
`ifdef MULT_CYCLE_COUNT_EN
  ,
  output logic [7:0] cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_BIT   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Counter value on the last multiplier bit; the shift that sees this value is the final one.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;

  // Registered copies of the state-decoded outputs, computed from the next state.
  logic load_q;
  logic busy_q;
  logic done_q;
  logic out_q;
  logic shift_st_q;  // shift strobe owned by the SHIFT state
  logic in_bit_q;    // high while the FSM sits in BIT, gates the lsb-dependent strobes

  // Sequencer: state, bit counter and registered outputs all advance together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_q      <= 1'b0;
      shift_st_q <= 1'b0;
      in_bit_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless the next state re-asserts them.
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shift_st_q <= 1'b0;
      in_bit_q   <= 1'b0;

      case (state)
        S_IDLE: begin
          // out_q is deliberately left alone so the last product stays visible.
          if (start) begin
            state   <= S_LOAD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            out_q   <= 1'b0;
            bit_cnt <= '0;
          end
        end

        S_LOAD: begin
          state    <= S_BIT;
          bit_cnt  <= '0;
          busy_q   <= 1'b1;
          in_bit_q <= 1'b1;
        end

        S_BIT: begin
          if (lsb) begin
            // Add this cycle, the matching shift follows in SHIFT.
            state      <= S_SHIFT;
            shift_st_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            // Shift-only bit: the shift happens in this cycle.
            bit_cnt <= bit_cnt + CNT_ONE;
            if (bit_cnt == LAST_BIT) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              out_q  <= 1'b1;
            end else begin
              state    <= S_BIT;
              busy_q   <= 1'b1;
              in_bit_q <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          bit_cnt <= bit_cnt + CNT_ONE;
          if (bit_cnt == LAST_BIT) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            out_q  <= 1'b1;
          end else begin
            state    <= S_BIT;
            busy_q   <= 1'b1;
            in_bit_q <= 1'b1;
          end
        end

        S_DONE: begin
          // start is ignored here; a held start is picked up one IDLE cycle later.
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          out_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULT_CYCLE_COUNT_EN
  // Busy-cycle counter: cleared on entry to LOAD, counts BIT/SHIFT cycles, saturates, holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= 8'd0;
    end else if (state == S_IDLE && start) begin
      cycle_count <= 8'd0;
    end else if ((state == S_BIT || state == S_SHIFT) && cycle_count != 8'hFF) begin
      cycle_count <= cycle_count + 8'd1;
    end
  end
`endif

  // BIT is Mealy on lsb; every other strobe comes straight from a register.
  assign load_signal  = load_q;
  assign add_signal   = in_bit_q & lsb;
  assign shift_signal = shift_st_q | (in_bit_q & ~lsb);
  assign out_signal   = out_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_mult_seq_controller.sv
// Bench for mult_seq_controller: drives a behavioural shift-and-add datapath from the strobes
// and compares latency, strobe counts, add positions and product against arithmetic expectations.
// Handles builds with or without MULT_CYCLE_COUNT_EN.
module tb_mult_seq_controller;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic lsb;
  logic load_signal, add_signal, shift_signal, out_signal, busy, done;
`ifdef MULT_CYCLE_COUNT_EN
  logic [7:0] cycle_count;
`endif

  mult_seq_controller #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .lsb          (lsb),
    .load_signal  (load_signal),
    .add_signal   (add_signal),
    .shift_signal (shift_signal),
    .out_signal   (out_signal),
    .busy         (busy),
    .done         (done)
`ifdef MULT_CYCLE_COUNT_EN
    ,
    .cycle_count  (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Datapath model: {acc, qreg} is the product register, acc[32] catches the adder carry.
  logic [31:0] mcand = '0;
  logic [31:0] mult  = '0;
  logic [32:0] acc   = '0;
  logic [31:0] qreg  = '0;
  assign lsb = qreg[0];

  always @(posedge clk) begin
    if (load_signal) begin
      acc  <= '0;
      qreg <= mult;
    end else if (add_signal) begin
      acc <= {1'b0, acc[31:0]} + {1'b0, mcand};
    end else if (shift_signal) begin
      qreg <= {acc[0], qreg[31:1]};
      acc  <= {1'b0, acc[32:1]};
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Per-cycle monitor: strobe tallies, exclusivity, add->shift pairing, add bit positions.
  int          n_load = 0, n_add = 0, n_shift = 0;
  int          excl_viol = 0, follow_viol = 0;
  int          cur_shift = 0;
  logic        prev_add = 1'b0;
  logic [31:0] add_mask = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_add = 1'b0;
    end else begin
      if ((int'(load_signal) + int'(add_signal) + int'(shift_signal)) > 1) excl_viol++;
      if (prev_add && shift_signal !== 1'b1) follow_viol++;
      prev_add = add_signal;
      if (load_signal) begin
        n_load++;
        add_mask  = '0;
        cur_shift = 0;
      end
      if (add_signal) begin
        n_add++;
        if (cur_shift < W) add_mask[cur_shift] = 1'b1;
      end
      if (shift_signal) begin
        n_shift++;
        cur_shift++;
      end
    end
  end

  // One full multiply. poke[0]: pulse start a few cycles into BIT; poke[1]: raise start during DONE.
  task automatic run_mult(input logic [31:0] m, input logic [31:0] q, input int poke, input string tag);
    int e0, off, exp_off, guard, ld0, sh0, ad0, busy_low, pop;
    logic got;
    logic [63:0] exp_p;
    pop     = $countones(q);
    exp_off = 1 + W + pop;
    exp_p   = {32'd0, m} * {32'd0, q};
    mcand   = m;
    mult    = q;
    @(negedge clk);
    ld0 = n_load; sh0 = n_shift; ad0 = n_add;
    start = 1'b1;
    @(negedge clk);
    e0    = edge_cnt;
    start = 1'b0;
    total++;
    if (load_signal !== 1'b1 || busy !== 1'b1 || out_signal !== 1'b0)
      $display("FAIL %s load_cycle: load=%b busy=%b out=%b want 1 1 0", tag, load_signal, busy, out_signal);
    else passed++;
    got = 1'b0; guard = 0; busy_low = 0;
    while (!got && guard < 300) begin
      @(negedge clk);
      guard++;
      if (poke[0] && guard == 3) start = 1'b1;
      if (poke[0] && guard == 4) start = 1'b0;
      if (done === 1'b1) got = 1'b1;
      else if (busy !== 1'b1) busy_low++;
    end
    off = edge_cnt - e0;
    total++;
    if (!got) $display("FAIL %s done_timeout: no done after %0d cycles", tag, guard);
    else passed++;
    total++;
    if (off !== exp_off) $display("FAIL %s latency: done %0d cycles after load, want %0d", tag, off, exp_off);
    else passed++;
    total++;
    if (busy_low !== 0) $display("FAIL %s busy_gap: busy low in %0d active cycles, want 0", tag, busy_low);
    else passed++;
    total++;
    if (busy !== 1'b0 || out_signal !== 1'b1)
      $display("FAIL %s done_cycle: busy=%b out=%b want 0 1", tag, busy, out_signal);
    else passed++;
    total++;
    if ({acc[31:0], qreg} !== exp_p)
      $display("FAIL %s product: got %h want %h", tag, {acc[31:0], qreg}, exp_p);
    else passed++;
    total++;
    if (n_shift - sh0 !== W) $display("FAIL %s shift_count: got %0d want %0d", tag, n_shift - sh0, W);
    else passed++;
    total++;
    if (n_add - ad0 !== pop) $display("FAIL %s add_count: got %0d want %0d", tag, n_add - ad0, pop);
    else passed++;
    total++;
    if (add_mask !== q) $display("FAIL %s add_positions: got %h want %h", tag, add_mask, q);
    else passed++;
`ifdef MULT_CYCLE_COUNT_EN
    total++;
    if (int'(cycle_count) !== ((W + pop > 255) ? 255 : W + pop))
      $display("FAIL %s cycle_count: got %0d want %0d", tag, cycle_count, (W + pop > 255) ? 255 : W + pop);
    else passed++;
`endif
    if (poke[1]) start = 1'b1;
    @(negedge clk);
    if (poke[1]) start = 1'b0;
    total++;
    if (done !== 1'b0 || out_signal !== 1'b1 || load_signal !== 1'b0)
      $display("FAIL %s after_done: done=%b out=%b load=%b want 0 1 0", tag, done, out_signal, load_signal);
    else passed++;
    @(negedge clk);
    total++;
    if (load_signal !== 1'b0 || busy !== 1'b0 || n_load - ld0 !== 1 || {acc[31:0], qreg} !== exp_p)
      $display("FAIL %s idle_hold: load=%b busy=%b loads=%0d want 0 0 1, product %h want %h",
               tag, load_signal, busy, n_load - ld0, {acc[31:0], qreg}, exp_p);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({load_signal, add_signal, shift_signal, out_signal, busy, done} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000",
               {load_signal, add_signal, shift_signal, out_signal, busy, done});
    else passed++;
`ifdef MULT_CYCLE_COUNT_EN
    total++;
    if (cycle_count !== 8'd0) $display("FAIL reset_cycle_count: got %0d want 0", cycle_count);
    else passed++;
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || load_signal !== 1'b0) $display("FAIL idle_no_start: busy=%b load=%b want 0 0", busy, load_signal);
    else passed++;
  endtask

  task automatic test_zero_multiplier();
    run_mult($urandom, 32'h0, 1, "zero_q_start_in_bit");
  endtask

  task automatic test_all_ones();
    run_mult($urandom, 32'hFFFF_FFFF, 0, "ones_q");
  endtask

  task automatic test_real_datapath();
    run_mult(32'd7, 32'd5, 0, "seven_x_five");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_mult($urandom, $urandom, 0, "random");
  endtask

  task automatic test_start_in_done();
    run_mult($urandom, $urandom, 2, "start_in_done");
  endtask

  task automatic test_back_to_back();
    int guard, ed, el;
    logic [63:0] exp_p;
    mcand = $urandom;
    mult  = $urandom;
    exp_p = {32'd0, mcand} * {32'd0, mult};
    @(negedge clk);
    start = 1'b1;
    guard = 0;
    while (done !== 1'b1 && guard < 300) begin @(negedge clk); guard++; end
    ed = edge_cnt;
    total++;
    if (done !== 1'b1 || {acc[31:0], qreg} !== exp_p)
      $display("FAIL b2b_first: done=%b product %h want 1 %h", done, {acc[31:0], qreg}, exp_p);
    else passed++;
    guard = 0;
    @(negedge clk);
    while (load_signal !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    el = edge_cnt;
    start = 1'b0;
    total++;
    if (load_signal !== 1'b1 || el - ed !== 2)
      $display("FAIL b2b_reload_gap: load=%b gap %0d want 1 2", load_signal, el - ed);
    else passed++;
    guard = 0;
    while (done !== 1'b1 && guard < 300) begin @(negedge clk); guard++; end
    total++;
    if (done !== 1'b1 || {acc[31:0], qreg} !== exp_p)
      $display("FAIL b2b_second: done=%b product %h want 1 %h", done, {acc[31:0], qreg}, exp_p);
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    int seen, guard;
    logic hit, saw_done;
    mcand = $urandom;
    mult  = $urandom | 32'h0000_0400;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; guard = 0; hit = 1'b0;
    while (!hit && guard < 200) begin
      @(negedge clk);
      guard++;
      if (shift_signal === 1'b1) begin
        if (seen == 10) hit = 1'b1;
        else seen++;
      end
    end
    total++;
    if (!hit) $display("FAIL reset_mid_reach: bit 10 shift not seen, shifts=%0d", seen);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({load_signal, add_signal, shift_signal, out_signal, busy, done} !== 6'b0)
      $display("FAIL reset_mid_outputs: got %b want 000000",
               {load_signal, add_signal, shift_signal, out_signal, busy, done});
    else passed++;
`ifdef MULT_CYCLE_COUNT_EN
    total++;
    if (cycle_count !== 8'd0) $display("FAIL reset_mid_cycle_count: got %0d want 0", cycle_count);
    else passed++;
`endif
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) $display("FAIL reset_mid_no_done: done or busy seen after abort, want none");
    else passed++;
    run_mult($urandom, $urandom, 0, "after_reset");
  endtask

  task automatic test_invariants();
    total++;
    if (excl_viol !== 0) $display("FAIL strobe_exclusive: %0d cycles with >1 strobe, want 0", excl_viol);
    else passed++;
    total++;
    if (follow_viol !== 0) $display("FAIL add_then_shift: %0d adds not followed by shift, want 0", follow_viol);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_multiplier();
    test_all_ones();
    test_real_datapath();
    test_random();
    test_start_in_done();
    test_back_to_back();
    test_reset_mid_shift();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_seq_controller.md
Name: mult_seq_controller

Overview:
- FSM that sequences the 32-bit sequential shift-and-accumulate multiplier datapath (shift register plus adder).
- Accepts a start request and drives the datapath control strobes: load_signal, add_signal, shift_signal, out_signal.
- Examines the shift register LSB once per multiplier bit to decide between add-then-shift and shift-only.
- Reports busy and done to the requesting logic.

Parameters:
- WIDTH, 32, number of multiplier bits, which equals the number of shift operations per multiply; legal range 2..64.
- CNT_W, $clog2(WIDTH)+1, width of the internal bit counter (derived; not to be overridden).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- start  input  1  multiply request; sampled only in IDLE.
- lsb  input  1  current shift-register bit 0 from the datapath.
- load_signal  output  1  datapath load strobe.
- add_signal  output  1  datapath "add pending" strobe.
- shift_signal  output  1  datapath shift strobe.
- out_signal  output  1  datapath product-output enable.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - All outputs are 0, including out_signal.
  - Reset mid-operation aborts the multiply with no done pulse. The datapath is not re-initialised by this block.
- States: IDLE, LOAD, BIT, SHIFT, DONE. Encoding is free.
- IDLE:
  - Outputs 0, except out_signal, which holds its previous value.
  - start=1 → LOAD.
- LOAD:
  - load_signal=1, busy=1, out_signal=0.
  - Counter cleared.
  - → BIT.
- BIT (Mealy on lsb, busy=1):
  - lsb=1: add_signal=1 → SHIFT. Counter unchanged.
  - lsb=0: shift_signal=1, counter+1. If counter==WIDTH-1 → DONE, else stay in BIT.
- SHIFT:
  - shift_signal=1, busy=1, counter+1.
  - If counter==WIDTH-1 → DONE, else → BIT.
- DONE:
  - done=1 for exactly one cycle, busy=0, out_signal=1.
  - → IDLE.
- out_signal stays 1 from DONE until the next LOAD, so the product stays visible between multiplies.
- Strobe exclusivity: at most one of load_signal, add_signal, shift_signal is 1 in any cycle. The bench checks this every cycle.
- Shift count: exactly WIDTH shift_signal pulses per multiply. Each add_signal is immediately followed, next cycle, by a shift_signal.
- Latency: if start is sampled at edge E, then
  - load_signal is high in cycle E+1;
  - done is high in cycle E+2+WIDTH+popcount(multiplier).
- start handling:
  - start outside IDLE (LOAD/BIT/SHIFT/DONE) is ignored, not queued.
  - start held high continuously gives back-to-back multiplies with one IDLE cycle between DONE and LOAD.
- lsb is sampled only in BIT and is don't-care in every other state.

Optional Feature:
- Macro MULT_CYCLE_COUNT_EN.
- When defined:
  - Adds output cycle_count [7:0], which clears in LOAD and increments every cycle in BIT/SHIFT, saturating at 255.
  - The value holds from DONE until the next LOAD.
  - Reset value is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=32):
- Multiplier Q=0x00000000, start pulse at edge E → load_signal at E+1, 32 shift_signal pulses, no add_signal, done at E+34, out_signal=1 from E+34 onward.
- Q=0xFFFFFFFF → 32 add/shift pairs alternating, done at E+66; with MULT_CYCLE_COUNT_EN, cycle_count=64.
- Q=0x00000005, using the real datapath → add_signal only at bits 0 and 2, done at E+36; product 7×5=35 on the out bus when out_signal=1.
- start asserted during BIT and during DONE → no extra load_signal and no state change; start held high → second LOAD exactly 2 cycles after done.
- reset=0 asserted mid-SHIFT (bit 10) → all outputs 0 immediately, no done; after release, start runs a full clean multiply.
- Every cycle of every test → at most one strobe high; exactly WIDTH shift_signal pulses per multiply.
